// File: rtl/id_stage.sv
// MIPS instruction-decode stage: 32-entry register file, subset decoder and ID/EX pipeline register.
// Optional macro REGFILE_BYPASS_EN makes a same-cycle write-back visible to the operand read.
module id_stage #(
  parameter int WIDTH     = 32,
  parameter int REG_COUNT = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pc_in,
  input  logic [31:0]      instruction,
  input  logic             stall,
  input  logic             flush,
  input  logic             wb_en,
  input  logic [4:0]       wb_dest,
  input  logic [WIDTH-1:0] wb_value,
  output logic [4:0]       src1,
  output logic [4:0]       src2,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] val_rs,
  output logic [WIDTH-1:0] val_rt,
  output logic [WIDTH-1:0] imm_ext,
  output logic [4:0]       dest,
  output logic [3:0]       exe_cmd,
  output logic             mem_read,
  output logic             mem_write,
  output logic             wb_en_out,
  output logic             is_imm,
  output logic [1:0]       br_type
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [3:0] CMD_ADD = 4'h0;
  localparam logic [3:0] CMD_SUB = 4'h1;
  localparam logic [3:0] CMD_AND = 4'h2;
  localparam logic [3:0] CMD_OR  = 4'h3;
  localparam logic [3:0] CMD_SLT = 4'h4;
  localparam logic [3:0] CMD_NOP = 4'hF;

  logic [WIDTH-1:0] regs_r [REG_COUNT];

  logic [5:0]       opcode_s;
  logic [5:0]       funct_s;
  logic [4:0]       rs_s;
  logic [4:0]       rt_s;
  logic [4:0]       rd_s;
  logic             unused_shamt_s;

  logic [WIDTH-1:0] rd_rs_s;
  logic [WIDTH-1:0] rd_rt_s;
  logic [WIDTH-1:0] dec_imm_s;
  logic [4:0]       dec_dest_s;
  logic [3:0]       dec_cmd_s;
  logic             dec_mr_s;
  logic             dec_mw_s;
  logic             dec_wb_s;
  logic             dec_imm_sel_s;
  logic [1:0]       dec_br_s;

  assign opcode_s       = instruction[31:26];
  assign rs_s           = instruction[25:21];
  assign rt_s           = instruction[20:16];
  assign rd_s           = instruction[15:11];
  assign funct_s        = instruction[5:0];
  assign unused_shamt_s = ^instruction[10:6];

  assign src1 = rs_s;
  assign src2 = rt_s;

  // Register file write port; register 0 is never written
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs_r[i] <= '0;
      end
    end else if (wb_en && (wb_dest != 5'd0)) begin
      regs_r[wb_dest] <= wb_value;
    end
  end

  // Operand read ports, optionally forwarding the same-cycle write-back
  always_comb begin
    rd_rs_s = '0;
    rd_rt_s = '0;
    if (rs_s == 5'd0) begin
      rd_rs_s = '0;
`ifdef REGFILE_BYPASS_EN
    end else if (wb_en && (wb_dest == rs_s)) begin
      rd_rs_s = wb_value;
`endif
    end else begin
      rd_rs_s = regs_r[rs_s];
    end
    if (rt_s == 5'd0) begin
      rd_rt_s = '0;
`ifdef REGFILE_BYPASS_EN
    end else if (wb_en && (wb_dest == rt_s)) begin
      rd_rt_s = wb_value;
`endif
    end else begin
      rd_rt_s = regs_r[rt_s];
    end
  end

  // Instruction decoder; anything unrecognised falls through as a NOP
  always_comb begin
    dec_imm_s     = {{(WIDTH-16){instruction[15]}}, instruction[15:0]};
    dec_dest_s    = 5'd0;
    dec_cmd_s     = CMD_NOP;
    dec_mr_s      = 1'b0;
    dec_mw_s      = 1'b0;
    dec_wb_s      = 1'b0;
    dec_imm_sel_s = 1'b0;
    dec_br_s      = 2'd0;
    case (opcode_s)
      OP_RTYPE: begin
        case (funct_s)
          FN_ADD:  begin dec_cmd_s = CMD_ADD; dec_wb_s = 1'b1; dec_dest_s = rd_s; end
          FN_SUB:  begin dec_cmd_s = CMD_SUB; dec_wb_s = 1'b1; dec_dest_s = rd_s; end
          FN_AND:  begin dec_cmd_s = CMD_AND; dec_wb_s = 1'b1; dec_dest_s = rd_s; end
          FN_OR:   begin dec_cmd_s = CMD_OR;  dec_wb_s = 1'b1; dec_dest_s = rd_s; end
          FN_SLT:  begin dec_cmd_s = CMD_SLT; dec_wb_s = 1'b1; dec_dest_s = rd_s; end
          default: dec_cmd_s = CMD_NOP;
        endcase
      end
      OP_ADDI: begin
        dec_cmd_s     = CMD_ADD;
        dec_imm_sel_s = 1'b1;
        dec_wb_s      = 1'b1;
        dec_dest_s    = rt_s;
      end
      OP_LW: begin
        dec_cmd_s     = CMD_ADD;
        dec_imm_sel_s = 1'b1;
        dec_mr_s      = 1'b1;
        dec_wb_s      = 1'b1;
        dec_dest_s    = rt_s;
      end
      OP_SW: begin
        dec_cmd_s     = CMD_ADD;
        dec_imm_sel_s = 1'b1;
        dec_mw_s      = 1'b1;
      end
      OP_BEQ:  dec_br_s = 2'd1;
      OP_BNE:  dec_br_s = 2'd2;
      OP_J: begin
        dec_br_s  = 2'd3;
        dec_imm_s = {{(WIDTH-26){1'b0}}, instruction[25:0]};
      end
      default: dec_cmd_s = CMD_NOP;
    endcase
  end

  // ID/EX boundary register: reset/flush load a NOP, stall holds
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      pc_out    <= '0;
      val_rs    <= '0;
      val_rt    <= '0;
      imm_ext   <= '0;
      dest      <= 5'd0;
      exe_cmd   <= CMD_NOP;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      wb_en_out <= 1'b0;
      is_imm    <= 1'b0;
      br_type   <= 2'd0;
    end else if (!stall) begin
      pc_out    <= pc_in;
      val_rs    <= rd_rs_s;
      val_rt    <= rd_rt_s;
      imm_ext   <= dec_imm_s;
      dest      <= dec_dest_s;
      exe_cmd   <= dec_cmd_s;
      mem_read  <= dec_mr_s;
      mem_write <= dec_mw_s;
      wb_en_out <= dec_wb_s;
      is_imm    <= dec_imm_sel_s;
      br_type   <= dec_br_s;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed vector table, a stall/write-back sequence,
// and randomized traffic checked against an architectural reference model.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush, wb_en;
  logic [4:0]  wb_dest;
  logic [31:0] wb_value, pc_in, instruction;
  logic [4:0]  src1, src2, dest;
  logic [31:0] pc_out, val_rs, val_rt, imm_ext;
  logic [3:0]  exe_cmd;
  logic        mem_read, mem_write, wb_en_out, is_imm;
  logic [1:0]  br_type;

  always #5 clk = ~clk;

  id_stage dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .instruction(instruction),
    .stall(stall), .flush(flush), .wb_en(wb_en), .wb_dest(wb_dest), .wb_value(wb_value),
    .src1(src1), .src2(src2), .pc_out(pc_out), .val_rs(val_rs), .val_rt(val_rt),
    .imm_ext(imm_ext), .dest(dest), .exe_cmd(exe_cmd), .mem_read(mem_read),
    .mem_write(mem_write), .wb_en_out(wb_en_out), .is_imm(is_imm), .br_type(br_type)
  );

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] pc, vrs, vrt, imm;
    logic [4:0]  dest;
    logic [3:0]  cmd;
    logic        mr, mw, wb, ii;
    logic [1:0]  br;
  } idex_t;

  typedef struct {
    bit          rst, stall, flush, wbe;
    logic [4:0]  wbd;
    logic [31:0] wbv, pc, ins;
    idex_t       exp;
  } vec_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] mdl_rf [32];
  idex_t       mdl_q;
  vec_t        tbl [$];

  function automatic idex_t mkx(input logic [31:0] pc, vrs, vrt, imm, input logic [4:0] d,
                                input logic [3:0] cmd, input logic mr, mw, wb, ii,
                                input logic [1:0] br);
    idex_t o;
    o.pc = pc; o.vrs = vrs; o.vrt = vrt; o.imm = imm; o.dest = d; o.cmd = cmd;
    o.mr = mr; o.mw = mw; o.wb = wb; o.ii = ii; o.br = br;
    return o;
  endfunction

  function automatic idex_t nop0();
    return mkx(32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
  endfunction

  function automatic vec_t mkv(input bit r, s, f, we, input logic [4:0] wd,
                               input logic [31:0] wv, pc, ins, input idex_t e);
    vec_t v;
    v.rst = r; v.stall = s; v.flush = f; v.wbe = we; v.wbd = wd; v.wbv = wv;
    v.pc = pc; v.ins = ins; v.exp = e;
    return v;
  endfunction

  // Architectural register read as seen by a decode in this cycle
  function automatic logic [31:0] mdl_read(input logic [4:0] idx);
    if (idx == 5'd0) return 32'h0;
    if (BYP && wb_en && (wb_dest == idx)) return wb_value;
    return mdl_rf[idx];
  endfunction

  function automatic idex_t mdl_decode(input logic [31:0] ins, input logic [31:0] pc);
    idex_t o;
    o = mkx(pc, mdl_read(ins[25:21]), mdl_read(ins[20:16]), {{16{ins[15]}}, ins[15:0]},
            5'd0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    case (ins[31:26])
      6'h00: begin
        case (ins[5:0])
          6'h20: o.cmd = 4'h0;
          6'h22: o.cmd = 4'h1;
          6'h24: o.cmd = 4'h2;
          6'h25: o.cmd = 4'h3;
          6'h2A: o.cmd = 4'h4;
          default: o.cmd = 4'hF;
        endcase
        if (o.cmd != 4'hF) begin o.wb = 1'b1; o.dest = ins[15:11]; end
      end
      6'h08: begin o.cmd = 4'h0; o.ii = 1'b1; o.wb = 1'b1; o.dest = ins[20:16]; end
      6'h23: begin o.cmd = 4'h0; o.ii = 1'b1; o.mr = 1'b1; o.wb = 1'b1; o.dest = ins[20:16]; end
      6'h2B: begin o.cmd = 4'h0; o.ii = 1'b1; o.mw = 1'b1; end
      6'h04: o.br = 2'd1;
      6'h05: o.br = 2'd2;
      6'h02: begin o.br = 2'd3; o.imm = {6'b0, ins[25:0]}; end
      default: o.cmd = 4'hF;
    endcase
    return o;
  endfunction

  // Advance the model by one clock edge using the inputs currently driven
  task automatic model_step();
    idex_t d;
    d = mdl_decode(instruction, pc_in);
    if (rst) begin
      for (int i = 0; i < 32; i++) mdl_rf[i] = 32'h0;
      mdl_q = nop0();
    end else begin
      if (flush) mdl_q = nop0();
      else if (!stall) mdl_q = d;
      if (wb_en && (wb_dest != 5'd0)) mdl_rf[wb_dest] = wb_value;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input idex_t e);
    chk({tag, ".pc_out"},    pc_out,           e.pc);
    chk({tag, ".val_rs"},    val_rs,           e.vrs);
    chk({tag, ".val_rt"},    val_rt,           e.vrt);
    chk({tag, ".imm_ext"},   imm_ext,          e.imm);
    chk({tag, ".dest"},      {27'd0, dest},    {27'd0, e.dest});
    chk({tag, ".exe_cmd"},   {28'd0, exe_cmd}, {28'd0, e.cmd});
    chk({tag, ".mem_read"},  {31'd0, mem_read},  {31'd0, e.mr});
    chk({tag, ".mem_write"}, {31'd0, mem_write}, {31'd0, e.mw});
    chk({tag, ".wb_en_out"}, {31'd0, wb_en_out}, {31'd0, e.wb});
    chk({tag, ".is_imm"},    {31'd0, is_imm},    {31'd0, e.ii});
    chk({tag, ".br_type"},   {30'd0, br_type},   {30'd0, e.br});
  endtask

  task automatic drive(input bit r, s, f, we, input logic [4:0] wd, input logic [31:0] wv, pc, ins);
    rst = r; stall = s; flush = f; wb_en = we; wb_dest = wd; wb_value = wv;
    pc_in = pc; instruction = ins;
  endtask

  // Check the combinational hazard ports, then clock once and settle
  task automatic tick();
    #2;
    chk("src1", {27'd0, src1}, {27'd0, instruction[25:21]});
    chk("src2", {27'd0, src2}, {27'd0, instruction[20:16]});
    model_step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rnd_instr();
    logic [4:0]  rs, rt, rd;
    logic [15:0] im;
    logic [5:0]  fn;
    rs = 5'($urandom_range(0, 7));
    rt = 5'($urandom_range(0, 7));
    rd = 5'($urandom_range(0, 31));
    im = 16'($urandom);
    case ($urandom_range(0, 5))
      0: fn = 6'h20;
      1: fn = 6'h22;
      2: fn = 6'h24;
      3: fn = 6'h25;
      4: fn = 6'h2A;
      default: fn = 6'($urandom);
    endcase
    case ($urandom_range(0, 9))
      0, 1: return {6'h00, rs, rt, rd, 5'd0, fn};
      2: return {6'h08, rs, rt, im};
      3: return {6'h23, rs, rt, im};
      4: return {6'h2B, rs, rt, im};
      5: return {6'h04, rs, rt, im};
      6: return {6'h05, rs, rt, im};
      7: return {6'h02, 26'($urandom)};
      8: return 32'h0;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] bv;
    bv = BYP ? 32'h000000A5 : 32'h0;
    tbl.push_back(mkv(1, 0, 0, 0, 5'd0, 32'h0,        32'h1234, 32'hFC000000, nop0()));
    tbl.push_back(mkv(0, 0, 0, 1, 5'd0, 32'hFFFFFFFF, 32'h04, 32'h00000000,
                      mkx(32'h04, 0, 0, 0, 5'd0, 4'hF, 0, 0, 0, 0, 2'd0)));
    tbl.push_back(mkv(0, 0, 0, 0, 5'd0, 32'h0,        32'h08, 32'h00001820,
                      mkx(32'h08, 0, 0, 32'h1820, 5'd3, 4'h0, 0, 0, 1, 0, 2'd0)));
    tbl.push_back(mkv(0, 0, 0, 1, 5'd5, 32'h12345678, 32'h0C, 32'h00000000,
                      mkx(32'h0C, 0, 0, 0, 5'd0, 4'hF, 0, 0, 0, 0, 2'd0)));
    tbl.push_back(mkv(0, 0, 0, 0, 5'd0, 32'h0,        32'h10, 32'h8CA7FFFC,
                      mkx(32'h10, 32'h12345678, 0, 32'hFFFFFFFC, 5'd7, 4'h0, 1, 0, 1, 1, 2'd0)));
    tbl.push_back(mkv(0, 0, 0, 0, 5'd0, 32'h0,        32'h14, 32'h10A50003,
                      mkx(32'h14, 32'h12345678, 32'h12345678, 32'h3, 5'd0, 4'hF, 0, 0, 0, 0, 2'd1)));
    tbl.push_back(mkv(0, 1, 0, 0, 5'd0, 32'h0,        32'h18, 32'h00A53022, tbl[5].exp));
    tbl.push_back(mkv(0, 1, 0, 0, 5'd0, 32'h0,        32'h1C, 32'h00A53022, tbl[5].exp));
    tbl.push_back(mkv(0, 1, 1, 0, 5'd0, 32'h0,        32'h20, 32'h00A53022, nop0()));
    tbl.push_back(mkv(0, 0, 0, 1, 5'd4, 32'h000000A5, 32'h24, 32'h00841025,
                      mkx(32'h24, bv, bv, 32'h1025, 5'd2, 4'h3, 0, 0, 1, 0, 2'd0)));
    tbl.push_back(mkv(0, 0, 0, 0, 5'd0, 32'h0,        32'h28, 32'h00841025,
                      mkx(32'h28, 32'hA5, 32'hA5, 32'h1025, 5'd2, 4'h3, 0, 0, 1, 0, 2'd0)));
    tbl.push_back(mkv(0, 0, 0, 0, 5'd0, 32'h0,        32'h2C, 32'hFC000000,
                      mkx(32'h2C, 0, 0, 0, 5'd0, 4'hF, 0, 0, 0, 0, 2'd0)));
    tbl.push_back(mkv(0, 0, 0, 0, 5'd0, 32'h0,        32'h30, 32'h0800ABCD,
                      mkx(32'h30, 0, 0, 32'h0000ABCD, 5'd0, 4'hF, 0, 0, 0, 0, 2'd3)));
    tbl.push_back(mkv(0, 0, 0, 1, 5'd9, 32'h7,        32'h34, 32'h00000000,
                      mkx(32'h34, 0, 0, 0, 5'd0, 4'hF, 0, 0, 0, 0, 2'd0)));
    tbl.push_back(mkv(1, 0, 0, 0, 5'd0, 32'h0,        32'h38, 32'h01290820, nop0()));
    tbl.push_back(mkv(0, 0, 0, 0, 5'd0, 32'h0,        32'h3C, 32'h01290820,
                      mkx(32'h3C, 0, 0, 32'h0820, 5'd1, 4'h0, 0, 0, 1, 0, 2'd0)));
    tbl.push_back(mkv(0, 0, 1, 0, 5'd0, 32'h0,        32'h40, 32'h01290820, nop0()));
    tbl.push_back(mkv(0, 0, 0, 0, 5'd0, 32'h0,        32'h44, 32'hACA30008,
                      mkx(32'h44, 0, 0, 32'h8, 5'd0, 4'h0, 0, 1, 0, 1, 2'd0)));
    tbl.push_back(mkv(0, 0, 0, 0, 5'd0, 32'h0,        32'h48, 32'h2002FFFF,
                      mkx(32'h48, 0, 0, 32'hFFFFFFFF, 5'd2, 4'h0, 0, 0, 1, 1, 2'd0)));

    drive(1, 0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0);
    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].stall, tbl[i].flush, tbl[i].wbe, tbl[i].wbd, tbl[i].wbv,
            tbl[i].pc, tbl[i].ins);
      tick();
      chk_all($sformatf("row%0d", i), tbl[i].exp);
    end

    // Write-back during a stall must land and be visible once the stall releases
    drive(0, 0, 0, 1, 5'd2, 32'h11, 32'h100, 32'h00430820);
    tick();
    chk_all("seqA", mdl_q);
    drive(0, 1, 0, 1, 5'd3, 32'h22, 32'h104, 32'h00430820);
    tick();
    chk_all("seqB", mdl_q);
    drive(0, 0, 0, 0, 5'd0, 32'h0, 32'h108, 32'h00430820);
    tick();
    chk("seqC.val_rs", val_rs, 32'h11);
    chk("seqC.val_rt", val_rt, 32'h22);
    chk_all("seqC", mdl_q);

    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 9) == 0), ($urandom_range(0, 1) == 1),
            5'($urandom_range(0, 7)), $urandom, $urandom, rnd_instr());
      tick();
      chk_all($sformatf("rnd%0d", n), mdl_q);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
